control_multi_ws: RTL and testbench

CONTROL_MULTI_WS -- requirements
Module: control_multi_ws

---
 rtl/control_multi_ws_if.sv | 46 ++++
 rtl/control_multi_ws.sv | 227 ++++++++++++++++++++++
 tb/tb_control_multi_ws.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_multi_ws_if.sv
//==============================================================================
// Module      : control_multi_ws_if
// Description : Opcode/memory-ready inputs and datapath control outputs of the
//               multi-cycle control unit, bundled with driver/unit modports.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface control_multi_ws_if;
   logic [6:0] Opcode;
   logic       iMemReady;
   logic       oEscreveIR;
   logic       oEscrevePC;
   logic       oEscrevePCCond;
   logic       oEscrevePCBack;
   logic [1:0] oOrigAULA;
   logic [1:0] oOrigBULA;
   logic [1:0] oMem2Reg;
   logic [1:0] oALUOp;
   logic       oOrigPC;
   logic       oIouD;
   logic       oRegWrite;
   logic       oMemWrite;
   logic       oMemRead;
   logic       oIllegal;
   logic       oRetire;
   logic [3:0] oState;

   modport master (
      output Opcode, iMemReady,
      input  oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
             oOrigAULA, oOrigBULA, oMem2Reg, oALUOp,
             oOrigPC, oIouD, oRegWrite, oMemWrite, oMemRead,
             oIllegal, oRetire, oState
   );

   modport slave (
      input  Opcode, iMemReady,
      output oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
             oOrigAULA, oOrigBULA, oMem2Reg, oALUOp,
             oOrigPC, oIouD, oRegWrite, oMemWrite, oMemRead,
             oIllegal, oRetire, oState
   );
endinterface

`default_nettype wire

// File: rtl/control_multi_ws.sv
//==============================================================================
// Module      : control_multi_ws
// Description : Multi-cycle RISC-V control FSM with programmable memory wait
//               states, optional AUIPC decode and halting/resuming trap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_multi_ws #(
   parameter int unsigned MEM_WAIT  = 2,
   parameter bit          EN_AUIPC  = 1'b1,
   parameter bit          TRAP_HALT = 1'b1
) (
   input  wire logic         iCLK,
   input  wire logic         iRST,
   control_multi_ws_if.slave bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      FETCH_WB = 4'd1,
      DECODE   = 4'd2,
      ADDR     = 4'd3,
      LW_MEM   = 4'd4,
      LW_WB    = 4'd5,
      SW_MEM   = 4'd6,
      EXEC     = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   localparam logic [3:0] c_WAIT_INIT  = 4'(MEM_WAIT);
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       w_mem_done;

   logic       w_escreve_ir, w_escreve_pc, w_escreve_pc_cond, w_escreve_pc_back;
   logic [1:0] w_orig_a, w_orig_b, w_mem2reg, w_alu_op;
   logic       w_orig_pc, w_iou_d, w_reg_write, w_mem_write, w_mem_read;
   logic       w_illegal, w_retire;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= FETCH;
         cnt_q   <= c_WAIT_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A memory access ends only once the wait budget is spent and memory agrees.
   assign w_mem_done = (cnt_q == 4'd0) && bus.iMemReady;

   always_comb begin
      state_d           = state_q;
      w_escreve_ir      = 1'b0;
      w_escreve_pc      = 1'b0;
      w_escreve_pc_cond = 1'b0;
      w_escreve_pc_back = 1'b0;
      w_orig_a          = 2'b00;
      w_orig_b          = 2'b00;
      w_mem2reg         = 2'b00;
      w_alu_op          = 2'b00;
      w_orig_pc         = 1'b0;
      w_iou_d           = 1'b0;
      w_reg_write       = 1'b0;
      w_mem_write       = 1'b0;
      w_mem_read        = 1'b0;
      w_illegal         = 1'b0;
      w_retire          = 1'b0;

      case (state_q)
         FETCH: begin
            w_mem_read = 1'b1;
            if (w_mem_done) state_d = FETCH_WB;
         end
         FETCH_WB: begin
            w_escreve_ir      = 1'b1;
            w_escreve_pc      = 1'b1;
            w_escreve_pc_back = 1'b1;
            w_orig_a          = 2'b10;
            w_orig_b          = 2'b01;
            state_d           = DECODE;
         end
         DECODE: begin
            w_orig_b = 2'b10;
            case (bus.Opcode)
               c_OPC_LOAD, c_OPC_STORE:           state_d = ADDR;
               c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI:  state_d = EXEC;
               c_OPC_AUIPC:                       state_d = EN_AUIPC ? EXEC : TRAP;
               c_OPC_BRANCH:                      state_d = BRANCH;
               c_OPC_JAL:                         state_d = JAL;
               c_OPC_JALR:                        state_d = JALR;
               default:                           state_d = TRAP;
            endcase
         end
         ADDR: begin
            w_orig_a = 2'b01;
            w_orig_b = 2'b10;
            state_d  = (bus.Opcode == c_OPC_LOAD) ? LW_MEM : SW_MEM;
         end
         LW_MEM: begin
            w_iou_d    = 1'b1;
            w_mem_read = 1'b1;
            if (w_mem_done) state_d = LW_WB;
         end
         LW_WB: begin
            w_mem2reg   = 2'b10;
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
            state_d     = FETCH;
         end
         SW_MEM: begin
            w_iou_d     = 1'b1;
            w_mem_write = 1'b1;
            if (w_mem_done) begin
               w_retire = 1'b1;
               state_d  = FETCH;
            end
         end
         EXEC: begin
            case (bus.Opcode)
               c_OPC_OP: begin
                  w_orig_a = 2'b01;
                  w_orig_b = 2'b00;
                  w_alu_op = 2'b10;
               end
               c_OPC_OPIMM: begin
                  w_orig_a = 2'b01;
                  w_orig_b = 2'b10;
                  w_alu_op = 2'b10;
               end
               c_OPC_LUI: begin
                  w_orig_a = 2'b10;
                  w_orig_b = 2'b10;
                  w_alu_op = 2'b11;
               end
               c_OPC_AUIPC: begin
                  w_orig_a = 2'b10;
                  w_orig_b = 2'b10;
                  w_alu_op = 2'b00;
               end
               default: ;
            endcase
            state_d = ALU_WB;
         end
         ALU_WB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            w_escreve_pc_cond = 1'b1;
            w_orig_a          = 2'b01;
            w_orig_pc         = 1'b1;
            w_alu_op          = 2'b01;
            w_retire          = 1'b1;
            state_d           = FETCH;
         end
         JAL: begin
            w_escreve_pc = 1'b1;
            w_orig_pc    = 1'b1;
            w_mem2reg    = 2'b01;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
            state_d      = FETCH;
         end
         JALR: begin
            w_escreve_pc = 1'b1;
            w_orig_a     = 2'b01;
            w_orig_b     = 2'b10;
            w_mem2reg    = 2'b01;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
            state_d      = FETCH;
         end
         TRAP: begin
            w_illegal = 1'b1;
            if (!TRAP_HALT) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reload the wait budget on every fresh entry into a memory-access state.
   always_comb begin
      cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
      if ((state_d != state_q) &&
          ((state_d == FETCH) || (state_d == LW_MEM) || (state_d == SW_MEM)))
         cnt_d = c_WAIT_INIT;
   end

   // Reset suppresses every architectural write and any retire indication.
   assign bus.oEscreveIR     = w_escreve_ir      & ~iRST;
   assign bus.oEscrevePC     = w_escreve_pc      & ~iRST;
   assign bus.oEscrevePCCond = w_escreve_pc_cond & ~iRST;
   assign bus.oEscrevePCBack = w_escreve_pc_back & ~iRST;
   assign bus.oRegWrite      = w_reg_write       & ~iRST;
   assign bus.oMemWrite      = w_mem_write       & ~iRST;
   assign bus.oRetire        = w_retire          & ~iRST;
   assign bus.oOrigAULA      = w_orig_a;
   assign bus.oOrigBULA      = w_orig_b;
   assign bus.oMem2Reg       = w_mem2reg;
   assign bus.oALUOp         = w_alu_op;
   assign bus.oOrigPC        = w_orig_pc;
   assign bus.oIouD          = w_iou_d;
   assign bus.oMemRead       = w_mem_read;
   assign bus.oIllegal       = w_illegal;
   assign bus.oState         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_control_multi_ws.sv
//==============================================================================
// Module      : tb_control_multi_ws
// Description : Directed self-checking bench for control_multi_ws.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_multi_ws;

   // Output vector layout: {IR,PC,PCCond,PCBack, A,B,M2R,ALU, OrigPC,IouD,RegW,MemW,MemR, Illegal,Retire}
   localparam logic [18:0] E_FETCH  = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00001, 2'b00};
   localparam logic [18:0] E_FWB    = {4'b1101, 2'b10, 2'b01, 2'b00, 2'b00, 5'b00000, 2'b00};
   localparam logic [18:0] E_DEC    = {4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 5'b00000, 2'b00};
   localparam logic [18:0] E_ADDR   = {4'b0000, 2'b01, 2'b10, 2'b00, 2'b00, 5'b00000, 2'b00};
   localparam logic [18:0] E_LWMEM  = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b01001, 2'b00};
   localparam logic [18:0] E_LWWB   = {4'b0000, 2'b00, 2'b00, 2'b10, 2'b00, 5'b00100, 2'b01};
   localparam logic [18:0] E_SW     = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b01010, 2'b00};
   localparam logic [18:0] E_SWR    = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b01010, 2'b01};
   localparam logic [18:0] E_EXOP   = {4'b0000, 2'b01, 2'b00, 2'b00, 2'b10, 5'b00000, 2'b00};
   localparam logic [18:0] E_EXIMM  = {4'b0000, 2'b01, 2'b10, 2'b00, 2'b10, 5'b00000, 2'b00};
   localparam logic [18:0] E_EXLUI  = {4'b0000, 2'b10, 2'b10, 2'b00, 2'b11, 5'b00000, 2'b00};
   localparam logic [18:0] E_EXAUI  = {4'b0000, 2'b10, 2'b10, 2'b00, 2'b00, 5'b00000, 2'b00};
   localparam logic [18:0] E_ALUWB  = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00100, 2'b01};
   localparam logic [18:0] E_BRANCH = {4'b0010, 2'b01, 2'b00, 2'b00, 2'b01, 5'b10000, 2'b01};
   localparam logic [18:0] E_JAL    = {4'b0100, 2'b00, 2'b00, 2'b01, 2'b00, 5'b10100, 2'b01};
   localparam logic [18:0] E_JALR   = {4'b0100, 2'b01, 2'b10, 2'b01, 2'b00, 5'b00100, 2'b01};
   localparam logic [18:0] E_TRAP   = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b10};

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BAD    = 7'b1111111;

   logic clk = 1'b0;
   logic rst0, rst1, rst2;
   int   n_checks = 0;
   int   n_errors = 0;

   control_multi_ws_if bus0 ();
   control_multi_ws_if bus1 ();
   control_multi_ws_if bus2 ();

   control_multi_ws #(.MEM_WAIT(2), .EN_AUIPC(1'b1), .TRAP_HALT(1'b1)) u_dut0 (
      .iCLK(clk), .iRST(rst0), .bus(bus0));
   control_multi_ws #(.MEM_WAIT(0), .EN_AUIPC(1'b0), .TRAP_HALT(1'b0)) u_dut1 (
      .iCLK(clk), .iRST(rst1), .bus(bus1));
   control_multi_ws #(.MEM_WAIT(3), .EN_AUIPC(1'b1), .TRAP_HALT(1'b1)) u_dut2 (
      .iCLK(clk), .iRST(rst2), .bus(bus2));

   always #5 clk = ~clk;

   function automatic logic [22:0] obs(input int k);
      case (k)
         0: return {bus0.oState, bus0.oEscreveIR, bus0.oEscrevePC, bus0.oEscrevePCCond, bus0.oEscrevePCBack,
                    bus0.oOrigAULA, bus0.oOrigBULA, bus0.oMem2Reg, bus0.oALUOp, bus0.oOrigPC, bus0.oIouD,
                    bus0.oRegWrite, bus0.oMemWrite, bus0.oMemRead, bus0.oIllegal, bus0.oRetire};
         1: return {bus1.oState, bus1.oEscreveIR, bus1.oEscrevePC, bus1.oEscrevePCCond, bus1.oEscrevePCBack,
                    bus1.oOrigAULA, bus1.oOrigBULA, bus1.oMem2Reg, bus1.oALUOp, bus1.oOrigPC, bus1.oIouD,
                    bus1.oRegWrite, bus1.oMemWrite, bus1.oMemRead, bus1.oIllegal, bus1.oRetire};
         default: return {bus2.oState, bus2.oEscreveIR, bus2.oEscrevePC, bus2.oEscrevePCCond, bus2.oEscrevePCBack,
                    bus2.oOrigAULA, bus2.oOrigBULA, bus2.oMem2Reg, bus2.oALUOp, bus2.oOrigPC, bus2.oIouD,
                    bus2.oRegWrite, bus2.oMemWrite, bus2.oMemRead, bus2.oIllegal, bus2.oRetire};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset0(input logic [6:0] opc);
      rst0 = 1'b1;
      bus0.Opcode = opc;
      bus0.iMemReady = 1'b1;
      tick();
      rst0 = 1'b0;
   endtask

   task automatic test_reset();
      logic [22:0] got;
      rst0 = 1'b1;
      tick();
      tick();
      rst0 = 1'b0;
      got = obs(0);
      n_checks++;
      if (got !== {4'd0, E_FETCH}) begin
         n_errors++;
         $display("FAIL reset_first_cycle: got %h expected %h", got, {4'd0, E_FETCH});
      end
      tick(); tick(); tick();
      got = obs(0);
      n_checks++;
      if (got !== {4'd1, E_FWB}) begin
         n_errors++;
         $display("FAIL reset_reach_fetch_wb: got %h expected %h", got, {4'd1, E_FWB});
      end
      rst0 = 1'b1;
      #1;
      got = obs(0);
      n_checks++;
      if ({got[18:15], bus0.oRegWrite, bus0.oMemWrite} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_gates_writes: got %b expected 000000",
                  {got[18:15], bus0.oRegWrite, bus0.oMemWrite});
      end
      tick();
      rst0 = 1'b0;
      n_checks++;
      if (bus0.oState !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_to_fetch: got %0d expected 0", bus0.oState);
      end
   endtask

   task automatic test_rtype();
      logic [22:0] exp_seq [7] = '{{4'd0, E_FETCH}, {4'd0, E_FETCH}, {4'd0, E_FETCH}, {4'd1, E_FWB},
                                   {4'd2, E_DEC}, {4'd7, E_EXOP}, {4'd8, E_ALUWB}};
      logic [22:0] got;
      int retires = 0;
      reset0(OPC_OP);
      for (int i = 0; i < 7; i++) begin
         got = obs(0);
         retires += int'(bus0.oRetire);
         n_checks++;
         if (got !== exp_seq[i]) begin
            n_errors++;
            $display("FAIL rtype_cycle%0d: got %h expected %h", i, got, exp_seq[i]);
         end
         tick();
      end
      n_checks++;
      if (bus0.oState !== 4'd0 || retires != 1) begin
         n_errors++;
         $display("FAIL rtype_end: state %0d retires %0d expected state 0 retires 1", bus0.oState, retires);
      end
   endtask

   task automatic test_exec_variants();
      logic [6:0]  opc;
      logic [18:0] exp_o;
      logic [22:0] got;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin opc = OPC_OPIMM; exp_o = E_EXIMM; end
            1:       begin opc = OPC_LUI;   exp_o = E_EXLUI; end
            default: begin opc = OPC_AUIPC; exp_o = E_EXAUI; end
         endcase
         reset0(opc);
         for (int t = 0; t < 5; t++) tick();
         got = obs(0);
         n_checks++;
         if (got !== {4'd7, exp_o}) begin
            n_errors++;
            $display("FAIL exec_variant%0d: got %h expected %h", i, got, {4'd7, exp_o});
         end
      end
   endtask

   task automatic test_control_flow();
      logic [6:0]  opc;
      logic [22:0] exp_v;
      logic [22:0] got;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin opc = OPC_BRANCH; exp_v = {4'd9,  E_BRANCH}; end
            1:       begin opc = OPC_JAL;    exp_v = {4'd10, E_JAL};    end
            default: begin opc = OPC_JALR;   exp_v = {4'd11, E_JALR};   end
         endcase
         reset0(opc);
         for (int t = 0; t < 5; t++) tick();
         got = obs(0);
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL control_flow%0d: got %h expected %h", i, got, exp_v);
         end
         tick();
         n_checks++;
         if (bus0.oState !== 4'd0) begin
            n_errors++;
            $display("FAIL control_flow%0d_return: got %0d expected 0", i, bus0.oState);
         end
      end
   endtask

   task automatic test_trap_halt();
      logic [22:0] got;
      int bad = 0;
      reset0(OPC_BAD);
      for (int t = 0; t < 5; t++) tick();
      for (int i = 0; i < 20; i++) begin
         got = obs(0);
         if (got !== {4'd12, E_TRAP}) bad++;
         tick();
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL trap_hold: %0d of 20 cycles wrong, last got %h expected %h", bad, got, {4'd12, E_TRAP});
      end
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      n_checks++;
      if (bus0.oState !== 4'd0 || bus0.oIllegal !== 1'b0) begin
         n_errors++;
         $display("FAIL trap_reset_exit: state %0d illegal %b expected 0 0", bus0.oState, bus0.oIllegal);
      end
   endtask

   task automatic test_reset_mid_store();
      logic [22:0] got;
      reset0(OPC_STORE);
      for (int t = 0; t < 7; t++) tick();
      got = obs(0);
      n_checks++;
      if (got !== {4'd6, E_SW}) begin
         n_errors++;
         $display("FAIL store2_second_cycle: got %h expected %h", got, {4'd6, E_SW});
      end
      rst0 = 1'b1;
      #1;
      n_checks++;
      if ({bus0.oMemWrite, bus0.oRetire} !== 2'b00 || bus0.oState !== 4'd6) begin
         n_errors++;
         $display("FAIL store2_reset_gate: memwrite %b retire %b state %0d expected 0 0 6",
                  bus0.oMemWrite, bus0.oRetire, bus0.oState);
      end
      tick();
      got = obs(0);
      rst0 = 1'b0;
      n_checks++;
      if (got !== {4'd0, E_FETCH}) begin
         n_errors++;
         $display("FAIL store2_after_reset: got %h expected %h", got, {4'd0, E_FETCH});
      end
      // Counter reloaded to 2, so FETCH persists two more cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus0.oState !== ((i == 2) ? 4'd1 : 4'd0)) begin
            n_errors++;
            $display("FAIL store2_refetch%0d: got %0d expected %0d", i, bus0.oState, (i == 2) ? 1 : 0);
         end
      end
   endtask

   task automatic test_load_wait();
      logic [22:0] got;
      logic [22:0] exp_seq [4] = '{{4'd0, E_FETCH}, {4'd1, E_FWB}, {4'd2, E_DEC}, {4'd3, E_ADDR}};
      rst1 = 1'b1;
      bus1.Opcode = OPC_LOAD;
      bus1.iMemReady = 1'b1;
      tick();
      rst1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         got = obs(1);
         n_checks++;
         if (got !== exp_seq[i]) begin
            n_errors++;
            $display("FAIL load_cycle%0d: got %h expected %h", i, got, exp_seq[i]);
         end
         if (i == 3) bus1.iMemReady = 1'b0;
         tick();
      end
      for (int j = 0; j < 5; j++) begin
         got = obs(1);
         n_checks++;
         if (got !== {4'd4, E_LWMEM}) begin
            n_errors++;
            $display("FAIL load_mem%0d: got %h expected %h", j, got, {4'd4, E_LWMEM});
         end
         if (j == 4) bus1.iMemReady = 1'b1;
         tick();
      end
      got = obs(1);
      n_checks++;
      if (got !== {4'd5, E_LWWB}) begin
         n_errors++;
         $display("FAIL load_wb: got %h expected %h", got, {4'd5, E_LWWB});
      end
   endtask

   task automatic test_auipc_disabled();
      logic [22:0] got;
      rst1 = 1'b1;
      bus1.Opcode = OPC_AUIPC;
      bus1.iMemReady = 1'b1;
      tick();
      rst1 = 1'b0;
      for (int t = 0; t < 3; t++) tick();
      got = obs(1);
      n_checks++;
      if (got !== {4'd12, E_TRAP}) begin
         n_errors++;
         $display("FAIL auipc_off_trap: got %h expected %h", got, {4'd12, E_TRAP});
      end
      tick();
      got = obs(1);
      n_checks++;
      if (got !== {4'd0, E_FETCH}) begin
         n_errors++;
         $display("FAIL trap_resume: got %h expected %h", got, {4'd0, E_FETCH});
      end
   endtask

   task automatic test_store_wait();
      logic [22:0] exp_seq [11] = '{{4'd0, E_FETCH}, {4'd0, E_FETCH}, {4'd0, E_FETCH}, {4'd0, E_FETCH},
                                    {4'd1, E_FWB}, {4'd2, E_DEC}, {4'd3, E_ADDR}, {4'd6, E_SW},
                                    {4'd6, E_SW}, {4'd6, E_SW}, {4'd6, E_SWR}};
      logic [22:0] got;
      int writes = 0;
      rst2 = 1'b1;
      bus2.Opcode = OPC_STORE;
      bus2.iMemReady = 1'b1;
      tick();
      rst2 = 1'b0;
      for (int i = 0; i < 11; i++) begin
         got = obs(2);
         writes += int'(bus2.oMemWrite);
         n_checks++;
         if (got !== exp_seq[i]) begin
            n_errors++;
            $display("FAIL store3_cycle%0d: got %h expected %h", i, got, exp_seq[i]);
         end
         tick();
      end
      n_checks++;
      if (writes != 4 || bus2.oState !== 4'd0) begin
         n_errors++;
         $display("FAIL store3_end: writes %0d state %0d expected 4 0", writes, bus2.oState);
      end
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      bus0.Opcode = OPC_OP; bus0.iMemReady = 1'b1;
      bus1.Opcode = OPC_OP; bus1.iMemReady = 1'b1;
      bus2.Opcode = OPC_OP; bus2.iMemReady = 1'b1;
      test_reset();
      test_rtype();
      test_exec_variants();
      test_control_flow();
      test_trap_halt();
      test_reset_mid_store();
      test_load_wait();
      test_auipc_disabled();
      test_store_wait();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
